// File: rtl/apb_pkg.sv
// Shared types for the APB multi-slave master: FSM states and captured response.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package apb_pkg;

    localparam int APB_RSP_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_t;

    // Response as captured for the requester; rdata sized for the default data width.
    typedef struct packed {
        logic [APB_RSP_W-1:0] rdata;
        logic                 err;
    } apb_rsp_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Maps a byte address to a slave index and flags addresses beyond the last slave.
// Latency: combinational.
// Backpressure: none.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_ADDR_W = 12
) (
    input  logic [ADDR_W-1:0]                    addr,
    output logic [idx_width(NUM_SLAVES)-1:0]     idx,
    output logic                                 mapped
);

    localparam int IDX_W = idx_width(NUM_SLAVES);

    logic [ADDR_W-1:0] slot;

    assign slot   = addr >> SLV_ADDR_W;
    assign mapped = (slot < ADDR_W'(NUM_SLAVES));
    assign idx    = slot[IDX_W-1:0];

endmodule

// File: rtl/apb_nslave_master.sv
// Single-outstanding command to APB bridge over NUM_SLAVES address windows, with wait timeout.
// Latency: zero-wait access responds 3 cycles after accept; unmapped responds after 1.
// Backpressure: cmd_ready only in IDLE; slaves stall via pready up to TIMEOUT cycles.
module apb_nslave_master
    import apb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_ADDR_W = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [NUM_SLAVES-1:0]        psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [ADDR_W-1:0]            paddr,
    output logic [DATA_W-1:0]            pwdata,
    input  logic [NUM_SLAVES-1:0]        pready,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]        pslverr
);

    localparam int IDX_W = idx_width(NUM_SLAVES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_t        state, state_nxt;
    apb_rsp_t          rsp_q, rsp_nxt;
    logic [IDX_W-1:0]  dec_idx, idx_q;
    logic              dec_mapped;
    logic [CNT_W-1:0]  wait_cnt;
    logic              cmd_fire, timeout_hit;
    logic              sel_ready, sel_err;
    logic [DATA_W-1:0] sel_rdata;

    apb_addr_decode #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_ADDR_W (SLV_ADDR_W)
    ) u_decode (
        .addr   (cmd_addr),
        .idx    (dec_idx),
        .mapped (dec_mapped)
    );

    // Only the slave latched at accept is ever looked at.
    assign sel_ready   = pready[idx_q];
    assign sel_err     = pslverr[idx_q];
    assign sel_rdata   = prdata[int'(idx_q)*DATA_W +: DATA_W];

    assign cmd_ready   = (state == ST_IDLE);
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    assign psel      = (state == ST_SETUP || state == ST_ACCESS) ? (NUM_SLAVES'(1) << idx_q) : '0;
    assign penable   = (state == ST_ACCESS);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = DATA_W'(rsp_q.rdata);
    assign rsp_err   = rsp_q.err;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rsp_nxt   = rsp_q;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (dec_mapped) begin
                        state_nxt = ST_SETUP;
                    end else begin
                        state_nxt     = ST_RESP;
                        rsp_nxt.rdata = '0;
                        rsp_nxt.err   = 1'b1;
                    end
                end
            end
            ST_SETUP: state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready) begin
                    state_nxt     = ST_RESP;
                    rsp_nxt.err   = sel_err;
                    rsp_nxt.rdata = pwrite ? '0 : APB_RSP_W'(sel_rdata);
                end else if (timeout_hit) begin
                    state_nxt     = ST_RESP;
                    rsp_nxt.rdata = '0;
                    rsp_nxt.err   = 1'b1;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command fields are frozen at accept so the bus stays stable while the requester moves on.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            paddr    <= '0;
            pwrite   <= 1'b0;
            pwdata   <= '0;
            idx_q    <= '0;
            rsp_q    <= '0;
            wait_cnt <= '0;
        end else begin
            if (cmd_fire) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
                idx_q  <= dec_idx;
            end
            rsp_q <= rsp_nxt;
            if (state == ST_ACCESS && !sel_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_nslave_master.sv
// Randomized bench for apb_nslave_master: behavioural slaves plus a per-command response model.
module tb_apb_nslave_master;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int NUM_SLAVES = 4;
    localparam int SLV_ADDR_W = 12;
    localparam int TIMEOUT    = 16;

    logic                         pclk = 1'b0;
    logic                         preset = 1'b1;
    logic                         cmd_valid = 1'b0;
    logic                         cmd_ready;
    logic                         cmd_write = 1'b0;
    logic [ADDR_W-1:0]            cmd_addr = '0;
    logic [DATA_W-1:0]            cmd_wdata = '0;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;
    logic [NUM_SLAVES-1:0]        psel;
    logic                         penable;
    logic                         pwrite;
    logic [ADDR_W-1:0]            paddr;
    logic [DATA_W-1:0]            pwdata;
    logic [NUM_SLAVES-1:0]        pready;
    logic [NUM_SLAVES*DATA_W-1:0] prdata;
    logic [NUM_SLAVES-1:0]        pslverr;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural slave configuration for the current transaction.
    int          cfg_wait  = 0;
    logic        cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = '0;
    int          acc_cnt;
    logic [NUM_SLAVES-1:0]        noise_rdy = '0;
    logic [NUM_SLAVES-1:0]        noise_err = '0;
    logic [NUM_SLAVES*DATA_W-1:0] noise_dat = '0;

    apb_nslave_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_ADDR_W (SLV_ADDR_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        noise_rdy <= NUM_SLAVES'($urandom);
        noise_err <= NUM_SLAVES'($urandom);
        noise_dat <= {$urandom, $urandom, $urandom, $urandom};
    end

    always @(posedge pclk or posedge preset) begin
        if (preset) acc_cnt <= 0;
        else if ((|psel) && penable) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    // A slave in its access phase answers from the config; every other input is noise.
    always_comb begin
        pready  = noise_rdy;
        pslverr = noise_err;
        prdata  = noise_dat;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel[i] && penable) begin
                pready[i]                 = (acc_cnt >= cfg_wait);
                pslverr[i]                = cfg_err;
                prdata[i*DATA_W +: DATA_W] = cfg_rdata;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int wait_c, input bit serr, input logic [31:0] rdat);
        int          idx, exp_lat, exp_acc, exp_setup;
        int          lat, acc, setup, bad_sel, bad_hold, bad_rsp_bus;
        bit          mapped, exp_err;
        logic [31:0] exp_rdata, last_rdata;
        logic [3:0]  exp_sel;
        logic        last_err;
        idx    = int'(addr >> SLV_ADDR_W);
        mapped = (idx < NUM_SLAVES);
        if (!mapped) begin
            exp_lat = 1; exp_acc = 0; exp_err = 1'b1; exp_rdata = '0;
        end else if (wait_c >= TIMEOUT) begin
            exp_lat = 2 + TIMEOUT; exp_acc = TIMEOUT; exp_err = 1'b1; exp_rdata = '0;
        end else begin
            exp_lat = 3 + wait_c; exp_acc = wait_c + 1; exp_err = serr;
            exp_rdata = wr ? 32'h0 : rdat;
        end
        exp_setup = mapped ? 1 : 0;
        exp_sel   = mapped ? 4'(1 << idx) : 4'h0;
        cfg_wait = wait_c; cfg_err = serr; cfg_rdata = rdat;

        @(negedge pclk);
        check_eq("cmd_ready_idle", {63'h0, cmd_ready}, 64'h1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom_range(0, 1);

        lat = 0; acc = 0; setup = 0; bad_sel = 0; bad_hold = 0; bad_rsp_bus = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge pclk);
            if (psel != 0 && psel != exp_sel) bad_sel++;
            if (psel != 0 && (paddr != addr || pwdata != wdata || pwrite != wr)) bad_hold++;
            if (psel != 0 && !penable) setup++;
            if (penable) acc++;
            if (penable && psel != exp_sel) bad_sel++;
            if (rsp_valid) begin
                lat = k;
                if (psel != 0 || penable) bad_rsp_bus++;
            end
        end
        check_eq($sformatf("latency@%h", addr), 64'(lat), 64'(exp_lat));
        check_eq($sformatf("access_cycles@%h", addr), 64'(acc), 64'(exp_acc));
        check_eq($sformatf("setup_cycles@%h", addr), 64'(setup), 64'(exp_setup));
        check_eq($sformatf("psel_value@%h", addr), 64'(bad_sel), 64'h0);
        check_eq($sformatf("bus_hold@%h", addr), 64'(bad_hold), 64'h0);
        check_eq($sformatf("bus_idle_in_resp@%h", addr), 64'(bad_rsp_bus), 64'h0);
        check_eq($sformatf("rsp_err@%h", addr), {63'h0, rsp_err}, {63'h0, exp_err});
        check_eq($sformatf("rsp_rdata@%h", addr), {32'h0, rsp_rdata}, {32'h0, exp_rdata});
        last_rdata = rsp_rdata; last_err = rsp_err;
        @(negedge pclk);
        check_eq("rsp_single_pulse", {63'h0, rsp_valid}, 64'h0);
        check_eq("cmd_ready_after_rsp", {63'h0, cmd_ready}, 64'h1);
        check_eq("rsp_hold", {31'h0, last_err, last_rdata}, {31'h0, rsp_err, rsp_rdata});
    endtask

    task automatic reset_mid_access();
        int seen, pulses;
        cfg_wait = 10; cfg_err = 1'b0; cfg_rdata = 32'h1111_2222;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_1008; cmd_wdata = 32'hA5A5_5A5A;
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge pclk);
            if (penable) seen = 1;
        end
        check_eq("rst_reached_access", 64'(seen), 64'h1);
        #2 preset = 1'b1;
        #1;
        check_eq("rst_psel", {60'h0, psel}, 64'h0);
        check_eq("rst_penable", {63'h0, penable}, 64'h0);
        check_eq("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        check_eq("rst_paddr", {32'h0, paddr}, 64'h0);
        @(negedge pclk);
        preset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge pclk);
            if (rsp_valid) pulses++;
        end
        check_eq("rst_no_response", 64'(pulses), 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got no summary, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          idx, wait_c;
        logic [31:0] addr;
        #23;
        check_eq("reset_psel", {60'h0, psel}, 64'h0);
        check_eq("reset_penable", {63'h0, penable}, 64'h0);
        check_eq("reset_pwrite", {63'h0, pwrite}, 64'h0);
        check_eq("reset_paddr", {32'h0, paddr}, 64'h0);
        check_eq("reset_pwdata", {32'h0, pwdata}, 64'h0);
        check_eq("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        check_eq("reset_rsp_rdata", {32'h0, rsp_rdata}, 64'h0);
        check_eq("reset_rsp_err", {63'h0, rsp_err}, 64'h0);
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        check_eq("reset_cmd_ready", {63'h0, cmd_ready}, 64'h1);

        run_cmd(1'b0, 32'h0000_2004, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
        run_cmd(1'b1, 32'h0000_1010, 32'h1234_5678, 3, 1'b0, 32'hDEAD_BEEF);
        run_cmd(1'b0, 32'h0000_5000, 32'h0, 0, 1'b0, 32'h7777_7777);
        run_cmd(1'b0, 32'h0000_0040, 32'h0, 1000, 1'b0, 32'h5555_AAAA);
        run_cmd(1'b0, 32'h0000_3008, 32'h0, 1, 1'b1, 32'h0BAD_F00D);
        run_cmd(1'b0, 32'h0000_2000, 32'h0, TIMEOUT - 1, 1'b0, 32'h1357_9BDF);
        reset_mid_access();
        run_cmd(1'b0, 32'h0000_1ABC, 32'h0, 2, 1'b0, 32'h2468_ACE0);

        for (int n = 0; n < 40; n++) begin
            idx    = $urandom_range(0, 5);
            addr   = (32'(idx) << SLV_ADDR_W) | 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0) addr = addr | 32'h8000_0000;
            wait_c = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                                 : $urandom_range(0, 4);
            run_cmd(1'($urandom_range(0, 1)), addr, $urandom, wait_c,
                    1'($urandom_range(0, 3) == 0), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_nslave_master.md
APB_NSLAVE_MASTER -- requirements
Module: apb_nslave_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter NUM_SLAVES, default 4, number of APB slaves (1..16).
REQ-004 SHALL have parameter SLV_ADDR_W, default 12, per-slave address window bits.
REQ-005 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles before abort (>=1).
REQ-006 SHALL have ports:
- pclk  in  1  sole clock, rising edge.
- preset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  error flag.
- psel  out  NUM_SLAVES  one-hot slave select.
- penable  out  1  APB access phase.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pready  in  NUM_SLAVES  per-slave ready.
- prdata  in  NUM_SLAVES*DATA_W  per-slave read data, slave i at bits [i*DATA_W +: DATA_W].
- pslverr  in  NUM_SLAVES  per-slave error.

Function
REQ-007 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-008 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clock edge where cmd_valid and cmd_ready are both 1.
REQ-009 Slave index SHALL be cmd_addr >> SLV_ADDR_W; index >= NUM_SLAVES SHALL mark the command unmapped.
REQ-010 A mapped accept SHALL go IDLE->SETUP. An unmapped accept SHALL go IDLE->RESP with no psel asserted.
REQ-011 The module SHALL register cmd_addr, cmd_write, cmd_wdata and the slave index at accept. paddr, pwrite and pwdata SHALL hold those values, unchanged, through SETUP and ACCESS.
REQ-012 SETUP SHALL drive psel[idx]=1, penable=0, and go to ACCESS unconditionally.
REQ-013 ACCESS SHALL drive psel[idx]=1, penable=1; only pready[idx], prdata[idx] and pslverr[idx] SHALL be observed.
REQ-014 ACCESS with pready[idx]=1 SHALL go to RESP, capturing rsp_err=pslverr[idx] and rsp_rdata=prdata[idx] for reads (0 for writes).
REQ-015 A wait counter SHALL count ACCESS cycles with pready[idx]=0. On reaching TIMEOUT, the module SHALL go to RESP with rsp_err=1 and rsp_rdata=0, deasserting psel and penable.
REQ-016 RESP SHALL drive rsp_valid=1 for exactly one cycle, then go to IDLE. Unmapped responses SHALL have rsp_err=1 and rsp_rdata=0.
REQ-017 Zero-wait latency: accept at cycle T, SETUP T+1, ACCESS T+2, rsp_valid T+3, cmd_ready high again T+4.
REQ-018 psel SHALL be all-zero and penable 0 in IDLE and RESP; at most one psel bit SHALL be high at any time.
REQ-019 rsp_rdata and rsp_err SHALL be stable while rsp_valid=1 and SHALL hold their last values otherwise.
REQ-020 pready edges outside ACCESS, or for non-selected slaves, SHALL be ignored.

Reset
REQ-021 On preset=1, the module SHALL enter IDLE asynchronously, including mid-transaction.
REQ-022 Reset SHALL set psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and wait counter=0; cmd_ready SHALL be 1 after reset release.
REQ-023 A transaction interrupted by reset SHALL produce no response.

Structure
REQ-024 The state enum and a response struct (rdata, err) SHALL live in package apb_pkg.
REQ-025 Address decoding (index, mapped flag) SHALL be a sub-module apb_addr_decode, parametrised by ADDR_W, NUM_SLAVES and SLV_ADDR_W.
REQ-026 The read-data/ready/error mux SHALL be combinational on the registered index; FSM and counter SHALL be single-clock registers.

Verification
REQ-027 Read from slave 2 at 0x2004, zero wait, prdata[2]=0xCAFEF00D -> psel=4'b0100 at T+1..T+2, rsp_valid at T+3, rsp_rdata=0xCAFEF00D, rsp_err=0.
REQ-028 Write 0x12345678 to 0x1010, slave 1 holds pready low 3 cycles -> ACCESS 4 cycles, pwdata stable throughout, rsp_err=0, rsp_rdata=0.
REQ-029 Command to 0x5000 (NUM_SLAVES=4) -> no psel, rsp_valid at T+1, rsp_err=1.
REQ-030 Slave 0 never asserts pready, TIMEOUT=16 -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.
REQ-031 Read with pslverr[3]=1 at pready -> rsp_err=1, rsp_rdata=prdata[3].
REQ-032 preset pulsed during ACCESS -> psel=0 and penable=0 immediately, no rsp_valid, next command completes normally.
